rca8_addsub: RTL and testbench
==============================

Name: rca8_addsub

Overview:
- 8-bit ripple-carry adder/subtractor with a registered output stage.
- `sub` selects the operation: 0 computes a+b, 1 computes a−b as two's-complement a + ~b + 1.
- Carry ripples through a chain of full-adder cells, one per bit.
- Used as a small datapath arithmetic leaf: operands in, result plus carry/overflow flags one clock later.

Parameters:
- WIDTH, 8, operand and result width in bits. The block is verified only at 8; other values are legal but untested.

Ports:
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A, unsigned or two's-complement.
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract.
- z  output  WIDTH  result, registered.
- cout  output  1  carry out of the MSB, registered.
- overflow  output  1  signed overflow flag, registered.
- out_valid  output  1  z/cout/overflow valid, registered.

Behaviour:
- Reset: while rst_n=0, z=0, cout=0, overflow=0, out_valid=0, applied immediately without waiting for a clock edge. Deassertion is sampled at the next rising clk edge.
- Combinational core:
  - b_eff = b XOR {WIDTH{sub}}.
  - c[0] = sub.
  - For each bit i: s[i] = a[i]^b_eff[i]^c[i]; c[i+1] = a[i]&b_eff[i] | c[i]&(a[i]^b_eff[i]).
  - The chain is a pure ripple through WIDTH full-adder instances. No lookahead.
- Flags:
  - cout = c[WIDTH].
  - overflow = c[WIDTH] ^ c[WIDTH−1], i.e. signed overflow.
  - Subtract mode: cout=1 means no borrow (a ≥ b unsigned); cout=0 means borrow.
- Latency: exactly 1 cycle. Operands presented at edge N appear on z/cout/overflow after edge N+1.
- Every rising edge with rst_n=1:
  - out_valid ← in_valid.
  - If in_valid=1, z/cout/overflow ← core outputs.
  - If in_valid=0, z/cout/overflow hold their previous values.
- No backpressure: the block accepts a new operand every cycle, giving full throughput.
- Wrap-around: the result is modulo 2^WIDTH. Examples: 0−1 → 255 with cout=0; 255+1 → 0 with cout=1.
- Switching `sub` between consecutive cycles is legal. Each result depends only on the a/b/sub sampled on its own in_valid cycle.
- Reset asserted mid-stream: outputs clear at once. The first valid result after release comes from operands presented at or after the first active edge.
- No X propagation from idle inputs: when in_valid=0, the contents of a/b/sub do not affect the outputs.

Decomposition:
- Shared package holds WIDTH_DEFAULT=8 and localparams OP_ADD=1'b0 and OP_SUB=1'b1.
- One natural sub-module: full_adder (a, b, cin → s, cout), instantiated WIDTH times by a generate loop.
- Top level contains the operand inversion, the generate chain, flag derivation and the output register.

Test Plan:
- Add sweep: sub=0, a=2k, b=k for k=0..31 → z=3k and cout=0 one cycle later (e.g. a=62, b=31 → z=93, cout=0).
- Subtract sweep: sub=1, a=2k, b=k for k=0..31 → z=k and cout=1 (e.g. a=62, b=31 → z=31; a=0, b=0 → z=0, cout=1).
- Carry/borrow wrap:
  - add a=200, b=100 → z=44, cout=1.
  - sub a=0, b=1 → z=255, cout=0.
  - add a=255, b=1 → z=0, cout=1.
- Signed overflow:
  - add a=127, b=1 → z=128, overflow=1.
  - sub a=128, b=1 → z=127, overflow=1.
  - add a=5, b=3 → overflow=0.
- Valid/hold: in_valid pattern 1,0,1 with changing operands → out_valid echoes the pattern one cycle late, and z holds during the 0 cycle.
- Async reset: assert rst_n=0 between clock edges while out_valid=1 → z/cout/overflow/out_valid clear without waiting for a clock edge. After release, the first result appears one cycle after the next in_valid=1.

Source files
------------

// File: rtl/rca8_addsub_pkg.sv
// Shared constants for the ripple-carry adder/subtractor.
package rca8_addsub_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : rca8_addsub_pkg

// File: rtl/rca8_addsub_full_adder.sv
// One-bit full-adder cell; the ripple chain is built from these.
module rca8_addsub_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : rca8_addsub_full_adder

// File: rtl/rca8_addsub.sv
// Ripple-carry adder/subtractor with a registered result, carry and signed-overflow stage.
module rca8_addsub
    import rca8_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign b_eff = (sub == OP_ADD) ? b : ~b;
    assign c[0]  = (sub == OP_SUB);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        rca8_addsub_full_adder u_fa (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Result/flags load only on valid cycles so idle operands never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z         <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z        <= s;
                cout     <= c[WIDTH];
                overflow <= c[WIDTH] ^ c[WIDTH-1];
            end
        end
    end

endmodule : rca8_addsub

// File: tb/tb_rca8_addsub.sv
// Directed self-checking bench for rca8_addsub.
module tb_rca8_addsub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] z;
    logic       cout;
    logic       overflow;
    logic       out_valid;

    int n_checks;
    int n_fail;

    rca8_addsub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .z         (z),
        .cout      (cout),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one operand set at the falling edge, then settle just after the capturing edge.
    task automatic drive_op(input logic [7:0] va, input logic [7:0] vb,
                            input logic vs, input logic vv);
        @(negedge clk);
        a        = va;
        b        = vb;
        sub      = vs;
        in_valid = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [7:0] ez,
                             input logic ec, input logic eo);
        check({tag, ".z"},        32'(z),         32'(ez));
        check({tag, ".cout"},     32'(cout),      32'(ec));
        check({tag, ".overflow"}, 32'(overflow),  32'(eo));
        check({tag, ".out_valid"},32'(out_valid), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;

        #2;
        check("rst.z",         32'(z),         32'd0);
        check("rst.cout",      32'(cout),      32'd0);
        check("rst.overflow",  32'(overflow),  32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) begin
            drive_op(8'(2 * k), 8'(k), 1'b0, 1'b1);
            check_res($sformatf("add_sweep%0d", k), 8'(3 * k), 1'b0, 1'b0);
        end

        for (int k = 0; k < 32; k++) begin
            drive_op(8'(2 * k), 8'(k), 1'b1, 1'b1);
            check_res($sformatf("sub_sweep%0d", k), 8'(k), 1'b1, 1'b0);
        end

        drive_op(8'd200, 8'd100, 1'b0, 1'b1);
        check_res("add_200_100", 8'd44, 1'b1, 1'b0);
        drive_op(8'd0, 8'd1, 1'b1, 1'b1);
        check_res("sub_0_1", 8'd255, 1'b0, 1'b0);
        drive_op(8'd255, 8'd1, 1'b0, 1'b1);
        check_res("add_255_1", 8'd0, 1'b1, 1'b0);

        drive_op(8'd127, 8'd1, 1'b0, 1'b1);
        check_res("add_127_1", 8'd128, 1'b0, 1'b1);
        drive_op(8'd128, 8'd1, 1'b1, 1'b1);
        check_res("sub_128_1", 8'd127, 1'b1, 1'b1);
        drive_op(8'd5, 8'd3, 1'b0, 1'b1);
        check_res("add_5_3", 8'd8, 1'b0, 1'b0);

        // Valid pattern 1,0,1: idle cycle carries junk operands that must not leak.
        drive_op(8'd10, 8'd20, 1'b0, 1'b1);
        check_res("hold_v1", 8'd30, 1'b0, 1'b0);
        drive_op(8'd99, 8'd200, 1'b1, 1'b0);
        check("hold_idle.out_valid", 32'(out_valid), 32'd0);
        check("hold_idle.z",         32'(z),         32'd30);
        check("hold_idle.cout",      32'(cout),      32'd0);
        check("hold_idle.overflow",  32'(overflow),  32'd0);
        drive_op(8'd7, 8'd3, 1'b1, 1'b1);
        check_res("hold_v2", 8'd4, 1'b1, 1'b0);

        // Mid-cycle async reset while a valid result is on the outputs.
        drive_op(8'd100, 8'd50, 1'b0, 1'b1);
        check_res("pre_rst", 8'd150, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.z",         32'(z),         32'd0);
        check("arst.cout",      32'(cout),      32'd0);
        check("arst.overflow",  32'(overflow),  32'd0);
        check("arst.out_valid", 32'(out_valid), 32'd0);

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        drive_op(8'd1, 8'd2, 1'b0, 1'b0);
        check("post_rst_idle.out_valid", 32'(out_valid), 32'd0);
        check("post_rst_idle.z",         32'(z),         32'd0);
        drive_op(8'd60, 8'd70, 1'b1, 1'b1);
        check_res("post_rst_first", 8'd246, 1'b0, 1'b0);
        drive_op(8'd0, 8'd0, 1'b0, 1'b0);
        check("post_rst_tail.out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rca8_addsub
